// File: rtl/core_bus_pkg.sv
// Shared definitions for the core's data-cache request bus and the
// writeback store state machine.
package core_bus_pkg;

  localparam logic [1:0] READ   = 2'd0;
  localparam logic [1:0] WRITE  = 2'd1;
  localparam logic [1:0] MEMORY = 2'd1;
  localparam logic [1:0] DATA   = 2'd1;

  typedef enum logic [2:0] {
    IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WAIT,
    RETIRE
  } wb_state_t;

  // Request tag layout is {op, space, kind, 7'b0}.
  function automatic logic [12:0] store_tag();
    return {WRITE, MEMORY, DATA, 7'b0};
  endfunction

endpackage

// File: rtl/wb_store_master.sv
// Two-beat write handshake on the data-cache bus: address beat, data beat,
// then wait for the response and spend one cycle acknowledging it.
module wb_store_master
  import core_bus_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              reqack_i,
  input  logic              respcyc_i,
  output logic              reqcyc_o,
  output logic [DATA_W-1:0] req_o,
  output logic [TAG_W-1:0]  reqtag_o,
  output logic              respack_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              finish_o,
  output wb_state_t         state_o
);

  wb_state_t         state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] req_q, req_d;
  logic [TAG_W-1:0]  reqtag_q, reqtag_d;
  logic              reqcyc_q, reqcyc_d;
  logic              respack_q, respack_d;
  logic              busy_q, busy_d;

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    case (state_q)
      IDLE:    if (start_i) state_d = ST_ADDR;
      ST_ADDR: if (reqack_i) state_d = ST_DATA;
      ST_DATA: if (reqack_i) state_d = respcyc_i ? RETIRE : ST_WAIT;
      ST_WAIT: if (respcyc_i) state_d = RETIRE;
      RETIRE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // req only changes on an accepted beat, so it is stable while stalled.
    if (state_q == IDLE && start_i) begin
      data_d = data_i;
      req_d  = DATA_W'(addr_i);
    end else if (state_q == ST_ADDR && reqack_i) begin
      req_d = data_q;
    end

    reqcyc_d  = (state_d == ST_ADDR) || (state_d == ST_DATA);
    busy_d    = reqcyc_d || (state_d == ST_WAIT);
    respack_d = (state_d == RETIRE);
    reqtag_d  = reqcyc_d ? TAG_W'(store_tag()) : '0;
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      data_q    <= '0;
      req_q     <= '0;
      reqtag_q  <= '0;
      reqcyc_q  <= 1'b0;
      respack_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      req_q     <= req_d;
      reqtag_q  <= reqtag_d;
      reqcyc_q  <= reqcyc_d;
      respack_q <= respack_d;
      busy_q    <= busy_d;
    end
  end

  assign reqcyc_o  = reqcyc_q;
  assign req_o     = req_q;
  assign reqtag_o  = reqtag_q;
  assign respack_o = respack_q;
  assign busy_o    = busy_q;
  assign done_o    = respack_q;
  assign finish_o  = respack_d;
  assign state_o   = state_q;

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits register results, performs stores through
// wb_store_master, and pulses retirement with the next RIP.
module writeback_stage
  import core_bus_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              opcodeValidIn,
  input  logic              canWritebackIn,
  input  logic [63:0]       currentRipIn,
  input  logic [31:0]       instructionLengthIn,
  input  logic [3:0]        destRegIn,
  input  logic              destRegValidIn,
  input  logic [DATA_W-1:0] destRegValueIn,
  input  logic [3:0]        destRegSpecialIn,
  input  logic              destRegSpecialValidIn,
  input  logic [DATA_W-1:0] destRegSpecialValueIn,
  input  logic              isMemoryAccessDestIn,
  input  logic [ADDR_W-1:0] memoryAddressDestIn,
  output logic              regWriteEnOut,
  output logic [3:0]        regWriteIdxOut,
  output logic [DATA_W-1:0] regWriteDataOut,
  output logic              specWriteEnOut,
  output logic [3:0]        specWriteIdxOut,
  output logic [DATA_W-1:0] specWriteDataOut,
  output logic              retireValidOut,
  output logic [63:0]       nextRipOut,
  output logic              wbStallOut,
  output logic              storeInProgressOut,
  output logic              reqcyc,
  output logic [DATA_W-1:0] req,
  output logic [TAG_W-1:0]  reqtag,
  input  logic              reqack,
  input  logic              respcyc,
  input  logic [63:0]       resp,
  output logic              respack
);

  typedef struct packed {
    logic              reg_en;
    logic [3:0]        reg_idx;
    logic [DATA_W-1:0] reg_data;
    logic              spec_en;
    logic [3:0]        spec_idx;
    logic [DATA_W-1:0] spec_data;
    logic [63:0]       next_rip;
  } commit_t;

  commit_t   pend_q, pend_d;
  commit_t   out_q, out_d;
  logic      retire_q, retire_d;
  logic      accept, accept_store, accept_alu;
  logic      mst_busy, mst_done, mst_finish;
  wb_state_t mst_state;
  commit_t   incoming;
  logic      resp_unused;

  assign resp_unused = ^resp;

  always_comb begin
    accept       = opcodeValidIn && canWritebackIn && (mst_state == IDLE);
    accept_store = accept && isMemoryAccessDestIn;
    accept_alu   = accept && !isMemoryAccessDestIn;

    incoming.reg_en    = destRegValidIn;
    incoming.reg_idx   = destRegIn;
    incoming.reg_data  = destRegValueIn;
    incoming.spec_en   = destRegSpecialValidIn;
    incoming.spec_idx  = destRegSpecialIn;
    incoming.spec_data = destRegSpecialValueIn;
    incoming.next_rip  = currentRipIn + 64'(instructionLengthIn);

    pend_d = pend_q;
    if (accept_store) pend_d = incoming;

    // Enables are pulses; index/data hold their last committed values.
    out_d         = out_q;
    out_d.reg_en  = 1'b0;
    out_d.spec_en = 1'b0;
    retire_d      = 1'b0;
    if (accept_alu) begin
      out_d    = incoming;
      retire_d = 1'b1;
    end else if (mst_finish) begin
      out_d    = pend_q;
      retire_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q   <= '0;
      out_q    <= '0;
      retire_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      out_q    <= out_d;
      retire_q <= retire_d;
    end
  end

  wb_store_master #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TAG_W (TAG_W)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .start_i  (accept_store),
    .addr_i   (memoryAddressDestIn),
    .data_i   (destRegValueIn),
    .reqack_i (reqack),
    .respcyc_i(respcyc),
    .reqcyc_o (reqcyc),
    .req_o    (req),
    .reqtag_o (reqtag),
    .respack_o(respack),
    .busy_o   (mst_busy),
    .done_o   (mst_done),
    .finish_o (mst_finish),
    .state_o  (mst_state)
  );

  // Stall drops in the RETIRE cycle so upstream advances into the next IDLE.
  assign wbStallOut         = accept_store || mst_busy;
  assign storeInProgressOut = mst_busy && !mst_done;
  assign regWriteEnOut      = out_q.reg_en;
  assign regWriteIdxOut     = out_q.reg_idx;
  assign regWriteDataOut    = out_q.reg_data;
  assign specWriteEnOut     = out_q.spec_en;
  assign specWriteIdxOut    = out_q.spec_idx;
  assign specWriteDataOut   = out_q.spec_data;
  assign nextRipOut         = out_q.next_rip;
  assign retireValidOut     = retire_q;

endmodule
